// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - state encoding for the bit-serial adder sequencer
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational 1-bit full adder
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder, LSB-first through one full-adder cell
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_sum, fa_carry;
    logic             last_bit;
    logic [WIDTH-1:0] s_next;

    fa_cell u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (c_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign s_next   = {fa_sum, s_sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_bit) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // sum/cout are only written on the final shift edge, so partial results never leak out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c_q   <= 1'b0;
            cnt_q <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        c_q   <= cin;
                        cnt_q <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    s_sr  <= s_next;
                    c_q   <= fa_carry;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        sum  <= s_next;
                        cout <= fa_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl (WIDTH 8 and 4)
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp8[$];
    logic [4:0] exp4[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: the adder is plain integer addition of the captured operands
    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
        return 9'(a) + 9'(b) + 9'(c);
    endfunction

    function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
        return 5'(a) + 5'(b) + 5'(c);
    endfunction

    // Monitor: pops expected results on every done pulse
    int         negcnt = 0;
    int         rise8 = 0;
    bit         prev_busy8 = 1'b0;
    int         last_done4 = -1;
    logic [4:0] prev4 = '0;

    always @(negedge clk) begin
        negcnt++;
        if (rst) begin
            prev_busy8 = 1'b0;
            last_done4 = -1;
        end else begin
            if (busy8 && !prev_busy8) rise8 = negcnt;
            if (done8) begin
                chk(negcnt - rise8 == 8, "latency8", negcnt - rise8, 8);
                if (exp8.size() == 0) chk(1'b0, "unexpected_done8", {cout8, sum8}, 0);
                else begin
                    logic [8:0] e;
                    e = exp8.pop_front();
                    chk({cout8, sum8} == e, "result8", {cout8, sum8}, e);
                end
            end
            prev_busy8 = busy8;

            if (done4) begin
                if (last_done4 >= 0)
                    chk(negcnt - last_done4 == 6, "period4", negcnt - last_done4, 6);
                last_done4 = negcnt;
                if (exp4.size() == 0) chk(1'b0, "unexpected_done4", {cout4, sum4}, 0);
                else begin
                    logic [4:0] e;
                    e = exp4.pop_front();
                    chk({cout4, sum4} == e, "result4", {cout4, sum4}, e);
                end
            end else begin
                chk({cout4, sum4} == prev4, "stable4", {cout4, sum4}, prev4);
            end
        end
        prev4 = {cout4, sum4};
    end

    task automatic wait_idle8();
        int n = 0;
        while (busy8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy8) chk(1'b0, "timeout_idle8", 1, 0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        wait_idle8();
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        exp8.push_back(ref8(a, b, c));
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk(busy8 == 0 && done8 == 0, "reset_ctrl", {busy8, done8}, 0);
        chk({cout8, sum8} == 0, "reset_result", {cout8, sum8}, 0);
        rst = 1'b0;
        @(negedge clk);

        issue8(8'h5A, 8'h33, 1'b0);
        issue8(8'hFF, 8'h01, 1'b0);
        issue8(8'hFF, 8'hFF, 1'b1);
        issue8(8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++)
            issue8(8'($urandom), 8'($urandom), 1'($urandom));

        // Start pulses mid-job at job cycles 2 and 5 must be ignored
        issue8(8'hC3, 8'h7E, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            start8 = (i == 1 || i == 4);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            chk(busy8 == 1'b1, "busy_during_job", busy8, 1);
            @(negedge clk);
        end
        start8 = 1'b0;
        wait_idle8();
        repeat (3) @(negedge clk);
        chk(exp8.size() == 0, "single_done", exp8.size(), 0);

        // Asynchronous reset in the middle of SHIFT cycle 3 discards the job
        wait_idle8();
        a8 = 8'h99; b8 = 8'h44; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk(busy8 == 0 && done8 == 0, "async_rst_ctrl", {busy8, done8}, 0);
        chk({cout8, sum8} == 0, "async_rst_result", {cout8, sum8}, 0);
        @(negedge clk);
        rst = 1'b0;
        issue8(8'h10, 8'h20, 1'b0);
        wait_idle8();

        // Held-high start, exhaustive WIDTH=4 operands
        @(negedge clk);
        for (int i = 0; i < 512; i++) begin
            int n;
            logic [8:0] v;
            v = 9'(i);
            a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; start4 = 1'b1;
            exp4.push_back(ref4(v[3:0], v[7:4], v[8]));
            @(negedge clk);
            n = 0;
            while (busy4 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (busy4) chk(1'b0, "timeout_idle4", 1, 0);
            if (i == 511) start4 = 1'b0;
        end

        for (int n = 0; n < 100 && (exp4.size() != 0 || exp8.size() != 0); n++)
            @(negedge clk);
        chk(exp8.size() == 0, "drain8", exp8.size(), 0);
        chk(exp4.size() == 0, "drain4", exp4.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
